// File: rtl/hoaaned_pkg.sv
// Shared definitions for the HOAANED approximate adder and its error monitor.
// Holds the monitor FSM state type and the default adder geometry.
package hoaaned_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } mon_state_e;

    // Operand width and lower/upper partition lengths of the approximate adder
    localparam int unsigned DefaultN   = 16;
    localparam int unsigned DefaultLpl = 6;
    localparam int unsigned DefaultUpl = 10;

endpackage

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |x - y| plus an inequality flag.
module abs_diff #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] diff_o,
    output logic         neq_o
);

    always_comb begin
        if (x_i >= y_i) begin
            diff_o = x_i - y_i;
        end else begin
            diff_o = y_i - x_i;
        end
        neq_o = (x_i != y_i);
    end

endmodule

// File: rtl/hoaaned_error_monitor.sv
// Streaming error-characterisation unit: recomputes the exact sum of each operand pair and
// accumulates error count, error-distance sum (saturating) and maximum over a sample window.
module hoaaned_error_monitor
    import hoaaned_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [N:0]       in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N:0]       ed_max
);

    localparam int unsigned SumW = ACC_W + 1;

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] win_len_q, win_len_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;

    logic             s1_valid_q, s1_valid_d;
    logic [N:0]       s1_exact_q, s1_exact_d;
    logic [N:0]       s1_approx_q, s1_approx_d;

    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
    logic [N:0]       ed_max_q, ed_max_d;

    logic [N:0]       ed;
    logic             ed_nz;
    logic [SumW-1:0]  sum_ext;
    logic             xfer;

    // in_ready depends only on registered state
    assign in_ready = (state_q == StRun) && (accepted_q < win_len_q);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign done     = (state_q == StDone);

    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign ed_sum       = ed_sum_q;
    assign ed_max       = ed_max_q;

    abs_diff #(
        .W (N + 1)
    ) u_abs_diff (
        .x_i    (s1_exact_q),
        .y_i    (s1_approx_q),
        .diff_o (ed),
        .neq_o  (ed_nz)
    );

    assign sum_ext = {1'b0, ed_sum_q} + SumW'(ed);

    always_comb begin
        state_d        = state_q;
        win_len_d      = win_len_q;
        accepted_d     = accepted_q;
        s1_valid_d     = xfer;
        s1_exact_d     = s1_exact_q;
        s1_approx_d    = s1_approx_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        ed_sum_d       = ed_sum_q;
        ed_max_d       = ed_max_q;

        if (xfer) begin
            s1_exact_d  = {1'b0, in_a} + {1'b0, in_b};
            s1_approx_d = in_approx;
        end

        // Stage 2: fold the registered sample into the statistics
        if (s1_valid_q) begin
            sample_count_d = sample_count_q + CNT_W'(1);
            err_count_d    = err_count_q + CNT_W'(ed_nz);
            ed_sum_d       = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            if (ed > ed_max_q) begin
                ed_max_d = ed;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    win_len_d      = win_len;
                    accepted_d     = '0;
                    sample_count_d = '0;
                    err_count_d    = '0;
                    ed_sum_d       = '0;
                    ed_max_d       = '0;
                    state_d        = (win_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (xfer) begin
                    accepted_d = accepted_q + CNT_W'(1);
                    if (accepted_q == win_len_q - CNT_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The last sample's statistics commit on the edge where stage 1 empties
                if (!s1_valid_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            win_len_q      <= '0;
            accepted_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_exact_q     <= '0;
            s1_approx_q    <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            ed_sum_q       <= '0;
            ed_max_q       <= '0;
        end else begin
            state_q        <= state_d;
            win_len_q      <= win_len_d;
            accepted_q     <= accepted_d;
            s1_valid_q     <= s1_valid_d;
            s1_exact_q     <= s1_exact_d;
            s1_approx_q    <= s1_approx_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            ed_sum_q       <= ed_sum_d;
            ed_max_q       <= ed_max_d;
        end
    end

endmodule

// File: tb/tb_hoaaned_error_monitor.sv
// Scoreboard bench for hoaaned_error_monitor: window statistics predicted from plain arithmetic
// on the issued samples, compared by a separate monitor when the window completes.
module tb_hoaaned_error_monitor;

    localparam int unsigned N     = 16;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned ACC_W = 48;

    typedef struct {
        longint sc;
        longint ec;
        longint sum;
        longint mx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [N:0]       in_approx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] ed_sum;
    logic [N:0]       ed_max;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [N-1:0] sa[$];
    logic [N-1:0] sb[$];
    logic [N:0]   sp[$];
    exp_t         sb_q[$];

    always #5 clk = ~clk;

    hoaaned_error_monitor #(
        .N     (N),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .win_len      (win_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_approx    (in_approx),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .ed_sum       (ed_sum),
        .ed_max       (ed_max)
    );

    task automatic chk(input string name, input longint act, input longint req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic add_sample(input int a, input int b, input int ap);
        sa.push_back(N'(a));
        sb.push_back(N'(b));
        sp.push_back((N + 1)'(ap));
    endtask

    // vmode: 0 = valid every cycle, 1 = every other cycle, 2 = random
    task automatic run_window(input int len, input int vmode, input bit mid_start,
                              input bit rst_drain);
        exp_t e;
        int   i;
        int   cyc;
        bit   xf;
        int   exact;
        int   ed;
        e = '{0, 0, 0, 0};
        for (int j = 0; j < len; j++) begin
            exact = int'(sa[j]) + int'(sb[j]);
            ed = (exact > int'(sp[j])) ? exact - int'(sp[j]) : int'(sp[j]) - exact;
            e.sc++;
            if (ed != 0) e.ec++;
            e.sum += ed;
            if (ed > e.mx) e.mx = ed;
        end
        sb_q.push_back(e);

        start = 1'b1;
        win_len = CNT_W'(len);
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (len == 0) begin
            chk("w0_done", done, 1);
            chk("w0_busy", busy, 0);
            chk("w0_ready", in_ready, 0);
        end else begin
            chk("start_busy", busy, 1);
            chk("start_ready", in_ready, 1);
            chk("start_clear", sample_count, 0);
        end

        i = 0;
        cyc = 0;
        while (i < len && cyc < 20 * len + 20) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_a = sa[i];
            in_b = sb[i];
            in_approx = sp[i];
            if (mid_start && cyc == 1) begin
                start = 1'b1;
                win_len = 2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            xf = in_valid && in_ready;
            @(posedge clk); #1;
            if (xf) i++;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (i < len) $display("FAIL window_xfer: got %0d transfers, expected %0d", i, len);
        total_cnt++;
        if (i == len) pass_cnt++;

        if (len > 0 && rst_drain) begin
            chk("rd_busy", busy, 1);
            #1 rst = 1'b1;
            #1;
            chk("rd_count", sample_count, 0);
            chk("rd_err", err_count, 0);
            chk("rd_sum", ed_sum, 0);
            chk("rd_max", ed_max, 0);
            chk("rd_flags", {busy, done, in_ready}, 0);
            void'(sb_q.pop_back());
            @(negedge clk);
            rst = 1'b0;
        end else if (len > 0) begin
            chk("drain_ready", in_ready, 0);
            chk("drain_busy", busy, 1);
            chk("drain_done", done, 0);
            @(negedge clk);
            @(negedge clk);
            chk("k1_done", done, 0);
            chk("k1_busy", busy, 1);
            @(negedge clk);
            chk("k2_done", done, 1);
            chk("k2_busy", busy, 0);
            in_valid = 1'b1;
            @(negedge clk);
            chk("done_ready", in_ready, 0);
            chk("done_count", sample_count, len);
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
        sa.delete();
        sb.delete();
        sp.delete();
    endtask

    // Monitor: a start honoured from IDLE/DONE arms a compare at the next done
    initial begin
        bit   pending;
        exp_t e;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (pending && done) begin
                    if (sb_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL sb_underflow: got done with empty scoreboard, expected entry");
                    end else begin
                        e = sb_q.pop_front();
                        chk("sample_count", sample_count, e.sc);
                        chk("err_count", err_count, e.ec);
                        chk("ed_sum", ed_sum, e.sum);
                        chk("ed_max", ed_max, e.mx);
                    end
                    pending = 1'b0;
                end
                if (start && !busy) pending = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        int ex;
        int ap;
        int k;
        rst = 1'b1;
        start = 1'b0;
        win_len = '0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_approx = '0;
        #2;
        chk("rst_flags", {in_ready, busy, done}, 0);
        chk("rst_stats", sample_count | err_count | ed_sum[CNT_W-1:0] | CNT_W'(ed_max), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        add_sample(16'h0003, 16'h0004, 17'h00008);
        run_window(1, 0, 1'b0, 1'b0);

        add_sample(16'hFFFF, 16'h0001, 17'h10000);
        add_sample(16'h1234, 16'h4321, 17'h05555);
        add_sample(16'h0000, 16'h0000, 17'h00000);
        add_sample(16'h8000, 16'h8000, 17'h10000);
        run_window(4, 0, 1'b0, 1'b0);

        add_sample(100, 0, 95);
        add_sample(150, 50, 209);
        add_sample(7, 9, 16);
        run_window(3, 0, 1'b0, 1'b0);

        for (int j = 0; j < 8; j++) add_sample(j * 1000, j + 1, j * 1000 + 1 + (j % 3));
        run_window(8, 1, 1'b0, 1'b0);

        run_window(0, 0, 1'b0, 1'b0);

        for (int j = 0; j < 5; j++) add_sample(j, 2 * j, 3 * j + j);
        run_window(5, 0, 1'b1, 1'b0);

        for (int j = 0; j < 3; j++) add_sample(40000, 40000, 1);
        run_window(3, 0, 1'b0, 1'b1);

        add_sample(10, 20, 33);
        add_sample(65535, 65535, 131070);
        run_window(2, 0, 1'b0, 1'b0);

        for (int w = 0; w < 8; w++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                a = $urandom_range(0, 65535);
                b = $urandom_range(0, 65535);
                ex = a + b;
                k = $urandom_range(1, 300);
                case ($urandom_range(0, 3))
                    0:       ap = ex;
                    1:       ap = (ex >= k) ? ex - k : 0;
                    2:       ap = (ex + k <= 131071) ? ex + k : 131071;
                    default: ap = $urandom_range(0, 131071);
                endcase
                add_sample(a, b, ap);
            end
            run_window(len, $urandom_range(0, 2), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
